// File: rtl/alu_issue_queue_pkg.sv
// Shared definitions for the ALU issue queue.
// Holds the opcode constants the queue cares about, the default physical
// register tag width, the per-entry payload struct and a helper that tells
// whether an opcode takes its second operand from the immediate.
package alu_pkg;

    localparam int PREG_W = 6;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Payload of one queue entry; valid/ready bits live in separate vectors
    // because they are control state and are the only bits that get reset.
    typedef struct packed {
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [PREG_W-1:0] pd;
        logic [31:0]       imm;
    } iq_entry_t;

    // ALU-immediate and load ops read imm instead of rs2.
    function automatic logic uses_imm(input logic [6:0] op);
        return (op == OP_ITYPE) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Bundle between dispatch/writeback/ALU and the issue queue.
// master: the environment (dispatch, writeback broadcast, ALU stage, flush)
// slave : the issue queue itself
// Signals: flush, disp_* (dispatch request + disp_ready), wb_* (wakeup
// broadcast), iss_* (selected micro-op + iss_ready), count (population).
interface alu_issue_queue_if
    import alu_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PREG_W = alu_pkg::PREG_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [6:0]        disp_opcode;
    logic [2:0]        disp_func3;
    logic [6:0]        disp_func7;
    logic [PREG_W-1:0] disp_ps1;
    logic [PREG_W-1:0] disp_ps2;
    logic [PREG_W-1:0] disp_pd;
    logic [31:0]       disp_imm;
    logic              disp_rs1_rdy;
    logic              disp_rs2_rdy;
    logic              wb_valid;
    logic [PREG_W-1:0] wb_pd;
    logic              iss_valid;
    logic              iss_ready;
    logic [6:0]        iss_opcode;
    logic [2:0]        iss_func3;
    logic [6:0]        iss_func7;
    logic [PREG_W-1:0] iss_ps1;
    logic [PREG_W-1:0] iss_ps2;
    logic [PREG_W-1:0] iss_pd;
    logic [31:0]       iss_imm;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, disp_valid, disp_opcode, disp_func3, disp_func7,
               disp_ps1, disp_ps2, disp_pd, disp_imm, disp_rs1_rdy, disp_rs2_rdy,
               wb_valid, wb_pd, iss_ready,
        input  disp_ready, iss_valid, iss_opcode, iss_func3, iss_func7,
               iss_ps1, iss_ps2, iss_pd, iss_imm, count
    );

    modport slave (
        input  flush, disp_valid, disp_opcode, disp_func3, disp_func7,
               disp_ps1, disp_ps2, disp_pd, disp_imm, disp_rs1_rdy, disp_rs2_rdy,
               wb_valid, wb_pd, iss_ready,
        output disp_ready, iss_valid, iss_opcode, iss_func3, iss_func7,
               iss_ps1, iss_ps2, iss_pd, iss_imm, count
    );

endinterface

// File: rtl/alu_issue_queue_age_matrix.sv
// Age matrix for oldest-first selection.
// Ports: clk, reset; wr_en/wr_idx mark the slot being allocated this cycle;
// valid is the current occupancy; req is the ready vector; grant is one-hot
// (or zero) marking the oldest requesting slot.
// old[i][j]=1 means slot i is older than slot j.
module iq_age_matrix
    import alu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant
);
    logic [DEPTH-1:0] old [DEPTH];
    logic [DEPTH-1:0] blocked;

    // A new entry is younger than everything currently held. Stale bits
    // in rows/columns of empty slots never matter: they are masked by req
    // and the row is cleared when the slot is reused.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) old[i] <= '0;
        end else if (wr_en) begin
            old[wr_idx] <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (valid[j] && (j != int'(wr_idx))) old[j][wr_idx] <= 1'b1;
            end
        end
    end

    // A requester wins if no other requester is older than it.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (req[j] && old[j][i]) blocked[i] = 1'b1;
            end
        end
    end

    assign grant = req & ~blocked;

endmodule

// File: rtl/alu_issue_queue.sv
// Out-of-order issue queue in front of the single integer ALU.
// Ports: clk, reset (sync, active-high) and an alu_issue_queue_if slave
// carrying dispatch, writeback wakeup, issue handshake, flush and count.
// Entries track source readiness by physical tag, wake on writeback, and
// the oldest fully-ready entry is presented combinationally on iss_*.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PREG_W = alu_pkg::PREG_W
) (
    input  logic            clk,
    input  logic            reset,
    alu_issue_queue_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    iq_entry_t        ent [DEPTH];
    iq_entry_t        sel;
    logic [DEPTH-1:0] valid, rdy1, rdy2, wake1, wake2, req, grant;
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_found, accept, fire, any_req, wb_live;
    logic             new_rdy1, new_rdy2;

    // disp_ready depends on registered count only, so an issue in the same
    // cycle never frees room for a same-cycle dispatch.
    assign bus.disp_ready = (count_q < CNT_W'(DEPTH));
    assign bus.count      = count_q;

    // Tag 0 is the zero register and is never "written back".
    assign wb_live = bus.wb_valid && (bus.wb_pd != '0);

    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid[i] && !alloc_found) begin
                alloc_idx   = IDX_W'(i);
                alloc_found = 1'b1;
            end
        end
    end

    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = wb_live && (ent[i].ps1 == bus.wb_pd);
            wake2[i] = wb_live && (ent[i].ps2 == bus.wb_pd);
        end
    end

    // Write-time readiness includes a bypass of this cycle's broadcast.
    assign new_rdy1 = bus.disp_rs1_rdy || (bus.disp_ps1 == '0) ||
                      (bus.wb_valid && (bus.wb_pd == bus.disp_ps1));
    assign new_rdy2 = bus.disp_rs2_rdy || (bus.disp_ps2 == '0) ||
                      (bus.wb_valid && (bus.wb_pd == bus.disp_ps2)) ||
                      uses_imm(bus.disp_opcode);

    assign req     = valid & rdy1 & rdy2;
    assign any_req = |req;
    assign accept  = bus.disp_valid && bus.disp_ready && alloc_found && !bus.flush;
    assign fire    = any_req && bus.iss_ready && !bus.flush;

    iq_age_matrix #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_age (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (accept),
        .wr_idx (alloc_idx),
        .valid  (valid),
        .req    (req),
        .grant  (grant)
    );

    // grant is one-hot or zero, so sel falls back to all-zero when idle.
    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) sel = ent[i];
        end
    end

    assign bus.iss_valid  = any_req;
    assign bus.iss_opcode = sel.opcode;
    assign bus.iss_func3  = sel.func3;
    assign bus.iss_func7  = sel.func7;
    assign bus.iss_ps1    = sel.ps1;
    assign bus.iss_ps2    = sel.ps2;
    assign bus.iss_pd     = sel.pd;
    assign bus.iss_imm    = sel.imm;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            valid   <= '0;
            rdy1    <= '0;
            rdy2    <= '0;
            count_q <= '0;
        end else begin
            rdy1  <= rdy1 | wake1;
            rdy2  <= rdy2 | wake2;
            valid <= valid & ~(fire ? grant : '0);
            if (accept) begin
                valid[alloc_idx] <= 1'b1;
                rdy1[alloc_idx]  <= new_rdy1;
                rdy2[alloc_idx]  <= new_rdy2;
            end
            count_q <= count_q + CNT_W'(accept) - CNT_W'(fire);
        end
    end

    // Payload storage carries no reset; it is only observed through valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent[alloc_idx] <= '{opcode: bus.disp_opcode, func3: bus.disp_func3,
                                func7: bus.disp_func7, ps1: bus.disp_ps1,
                                ps2: bus.disp_ps2, pd: bus.disp_pd,
                                imm: bus.disp_imm};
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios followed by
// randomized traffic against an age-ordered list model.
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_issue_queue_if #(.DEPTH(DEPTH), .PREG_W(6)) bus ();

    alu_issue_queue #(.DEPTH(DEPTH), .PREG_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference: list of held micro-ops in dispatch order (front = oldest).
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [5:0]  ps1, ps2, pd;
        logic [31:0] imm;
        bit          r1, r2;
    } m_t;
    m_t mq[$];

    int          e_idx;
    logic        e_valid;
    logic [66:0] e_pay;
    logic [3:0]  e_count;
    logic        e_dready;

    function automatic logic [66:0] pay_of(m_t m);
        return {m.op, m.f3, m.f7, m.ps1, m.ps2, m.pd, m.imm};
    endfunction

    function automatic logic [66:0] act_pay();
        return {bus.iss_opcode, bus.iss_func3, bus.iss_func7, bus.iss_ps1,
                bus.iss_ps2, bus.iss_pd, bus.iss_imm};
    endfunction

    task automatic model_eval();
        e_idx = -1;
        foreach (mq[k]) if (e_idx < 0 && mq[k].r1 && mq[k].r2) e_idx = k;
        e_valid  = (e_idx >= 0);
        e_pay    = e_valid ? pay_of(mq[e_idx]) : '0;
        e_count  = 4'(mq.size());
        e_dready = (mq.size() < DEPTH);
    endtask

    task automatic model_commit();
        m_t n;
        bit acc;
        if (reset || bus.flush) begin
            mq.delete();
            return;
        end
        acc = bus.disp_valid && (mq.size() < DEPTH);
        if (acc) begin
            n.op  = bus.disp_opcode; n.f3 = bus.disp_func3; n.f7 = bus.disp_func7;
            n.ps1 = bus.disp_ps1;    n.ps2 = bus.disp_ps2;  n.pd = bus.disp_pd;
            n.imm = bus.disp_imm;
            n.r1 = bus.disp_rs1_rdy || bus.disp_ps1 == 0 || (bus.wb_valid && bus.wb_pd == bus.disp_ps1);
            n.r2 = bus.disp_rs2_rdy || bus.disp_ps2 == 0 || (bus.wb_valid && bus.wb_pd == bus.disp_ps2) ||
                   bus.disp_opcode == OP_ITYPE || bus.disp_opcode == OP_LOAD;
        end
        if (e_valid && bus.iss_ready) mq.delete(e_idx);
        if (bus.wb_valid && bus.wb_pd != 0) begin
            foreach (mq[k]) begin
                if (mq[k].ps1 == bus.wb_pd) mq[k].r1 = 1;
                if (mq[k].ps2 == bus.wb_pd) mq[k].r2 = 1;
            end
        end
        if (acc) mq.push_back(n);
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_eval();
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.disp_valid = 0; bus.disp_opcode = 0; bus.disp_func3 = 0;
        bus.disp_func7 = 0; bus.disp_ps1 = 0; bus.disp_ps2 = 0; bus.disp_pd = 0;
        bus.disp_imm = 0; bus.disp_rs1_rdy = 0; bus.disp_rs2_rdy = 0;
        bus.wb_valid = 0; bus.wb_pd = 0;
    endtask

    task automatic drive_disp(input logic [6:0] op, input logic [6:0] f7,
                              input logic [5:0] ps1, input logic [5:0] ps2,
                              input logic [5:0] pd, input logic [31:0] imm,
                              input logic r1, input logic r2);
        bus.disp_valid = 1; bus.disp_opcode = op; bus.disp_func3 = 3'd0;
        bus.disp_func7 = f7; bus.disp_ps1 = ps1; bus.disp_ps2 = ps2;
        bus.disp_pd = pd; bus.disp_imm = imm; bus.disp_rs1_rdy = r1; bus.disp_rs2_rdy = r2;
    endtask

    task automatic test_reset();
        idle_inputs(); bus.iss_ready = 0; reset = 1;
        advance(); advance();
        reset = 0;
        settle();
        total++; if (bus.disp_ready !== 1'b1) begin bad++; $display("FAIL reset_disp_ready got=%0b exp=1", bus.disp_ready); end
        total++; if (bus.iss_valid !== 1'b0) begin bad++; $display("FAIL reset_iss_valid got=%0b exp=0", bus.iss_valid); end
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (act_pay() !== 67'd0) begin bad++; $display("FAIL reset_iss_fields got=%h exp=0", act_pay()); end
        advance();
    endtask

    task automatic test_basic_issue();
        bus.iss_ready = 1;
        drive_disp(OP_RTYPE, 7'd0, 6'd5, 6'd6, 6'd7, 32'd0, 1, 1);
        settle();
        total++; if (bus.iss_valid !== 1'b0) begin bad++; $display("FAIL basic_before got=%0b exp=0", bus.iss_valid); end
        advance(); idle_inputs();
        settle();
        total++; if (bus.iss_valid !== 1'b1 || bus.iss_pd !== 6'd7) begin bad++; $display("FAIL basic_issue valid=%0b pd=%0d exp 1/7", bus.iss_valid, bus.iss_pd); end
        total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL basic_count1 got=%0d exp=1", bus.count); end
        advance();
        settle();
        total++; if (bus.count !== 4'd0 || bus.iss_valid !== 1'b0) begin bad++; $display("FAIL basic_drain count=%0d valid=%0b exp 0/0", bus.count, bus.iss_valid); end
        advance();
    endtask

    task automatic test_wakeup();
        bus.iss_ready = 1;
        for (int mode = 0; mode < 2; mode++) begin
            drive_disp(OP_RTYPE, 7'b0100000, 6'd9, 6'd0, 6'd10, 32'd0, 0, 0);
            if (mode == 1) begin bus.wb_valid = 1; bus.wb_pd = 6'd9; end
            advance(); idle_inputs();
            settle();
            if (mode == 0) begin
                total++; if (bus.iss_valid !== 1'b0 || bus.count !== 4'd1) begin bad++; $display("FAIL wake_wait valid=%0b count=%0d exp 0/1", bus.iss_valid, bus.count); end
                bus.wb_valid = 1; bus.wb_pd = 6'd9;
                advance(); idle_inputs();
                settle();
            end
            total++; if (bus.iss_valid !== 1'b1 || bus.iss_pd !== 6'd10 || bus.iss_func7 !== 7'b0100000) begin
                bad++; $display("FAIL wake_issue mode=%0d valid=%0b pd=%0d f7=%h exp 1/10/20", mode, bus.iss_valid, bus.iss_pd, bus.iss_func7);
            end
            advance();
            settle();
            total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL wake_drain mode=%0d count=%0d exp=0", mode, bus.count); end
        end
        advance();
    endtask

    task automatic test_age_order();
        bus.iss_ready = 0;
        drive_disp(OP_RTYPE, 7'd0, 6'd12, 6'd0, 6'd20, 32'd0, 0, 0);
        advance();
        drive_disp(OP_RTYPE, 7'd0, 6'd1, 6'd2, 6'd21, 32'd0, 1, 1);
        advance(); idle_inputs();
        settle();
        total++; if (bus.iss_valid !== 1'b1 || bus.iss_pd !== 6'd21) begin bad++; $display("FAIL age_young_first valid=%0b pd=%0d exp 1/21", bus.iss_valid, bus.iss_pd); end
        bus.wb_valid = 1; bus.wb_pd = 6'd12;
        advance(); idle_inputs();
        for (int k = 0; k < 3; k++) begin
            settle();
            total++; if (bus.iss_pd !== 6'd20 || bus.iss_ps1 !== 6'd12) begin bad++; $display("FAIL age_old_stable cyc=%0d pd=%0d exp=20", k, bus.iss_pd); end
            if (k < 2) advance();
        end
        bus.iss_ready = 1;
        advance();
        settle();
        total++; if (bus.iss_pd !== 6'd21 || bus.count !== 4'd1) begin bad++; $display("FAIL age_second pd=%0d count=%0d exp 21/1", bus.iss_pd, bus.count); end
        advance();
        settle();
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL age_drain count=%0d exp=0", bus.count); end
        advance();
    endtask

    task automatic test_imm();
        bus.iss_ready = 1;
        drive_disp(OP_ITYPE, 7'd0, 6'd3, 6'd33, 6'd4, 32'hFFFF_FFFB, 1, 0);
        advance(); idle_inputs();
        settle();
        total++; if (bus.iss_valid !== 1'b1 || bus.iss_pd !== 6'd4 || bus.iss_imm !== 32'hFFFF_FFFB || bus.iss_opcode !== OP_ITYPE) begin
            bad++; $display("FAIL imm_issue valid=%0b pd=%0d imm=%h op=%b", bus.iss_valid, bus.iss_pd, bus.iss_imm, bus.iss_opcode);
        end
        advance();
    endtask

    task automatic test_full();
        bus.iss_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_disp(OP_RTYPE, 7'd0, 6'(40 + i), 6'd0, 6'(i + 1), 32'(i), 0, 0);
            advance();
        end
        drive_disp(OP_RTYPE, 7'd0, 6'd0, 6'd0, 6'd63, 32'd0, 1, 1);
        settle();
        total++; if (bus.count !== 4'd8 || bus.disp_ready !== 1'b0) begin bad++; $display("FAIL full_state count=%0d ready=%0b exp 8/0", bus.count, bus.disp_ready); end
        advance(); idle_inputs();
        settle();
        total++; if (bus.count !== 4'd8 || bus.iss_valid !== 1'b0) begin bad++; $display("FAIL full_ignore count=%0d valid=%0b exp 8/0", bus.count, bus.iss_valid); end
        bus.wb_valid = 1; bus.wb_pd = 6'd43;
        advance(); idle_inputs();
        bus.iss_ready = 1;
        drive_disp(OP_RTYPE, 7'd0, 6'd0, 6'd0, 6'd62, 32'd0, 1, 1);
        settle();
        total++; if (bus.iss_valid !== 1'b1 || bus.iss_pd !== 6'd4 || bus.disp_ready !== 1'b0) begin
            bad++; $display("FAIL full_wake valid=%0b pd=%0d ready=%0b exp 1/4/0", bus.iss_valid, bus.iss_pd, bus.disp_ready);
        end
        advance(); idle_inputs(); bus.iss_ready = 0;
        settle();
        total++; if (bus.count !== 4'd7 || bus.disp_ready !== 1'b1 || bus.iss_valid !== 1'b0) begin
            bad++; $display("FAIL full_freed count=%0d ready=%0b valid=%0b exp 7/1/0", bus.count, bus.disp_ready, bus.iss_valid);
        end
        bus.flush = 1;
        advance(); idle_inputs();
    endtask

    task automatic test_flush_reset();
        for (int mode = 0; mode < 2; mode++) begin
            bus.iss_ready = 0;
            drive_disp(OP_RTYPE, 7'd0, 6'd1, 6'd2, 6'd30, 32'd0, 1, 1);
            advance();
            for (int i = 0; i < 3; i++) begin
                drive_disp(OP_STORE, 7'd0, 6'(50 + i), 6'd0, 6'd0, 32'd8, 0, 0);
                advance();
            end
            idle_inputs();
            settle();
            total++; if (bus.count !== 4'd4 || bus.iss_valid !== 1'b1) begin bad++; $display("FAIL fl_setup mode=%0d count=%0d valid=%0b exp 4/1", mode, bus.count, bus.iss_valid); end
            drive_disp(OP_RTYPE, 7'd0, 6'd1, 6'd2, 6'd31, 32'd0, 1, 1);
            bus.iss_ready = 1; bus.wb_valid = 1; bus.wb_pd = 6'd50;
            if (mode == 0) bus.flush = 1; else reset = 1;
            advance(); idle_inputs(); reset = 0; bus.iss_ready = 0;
            settle();
            total++; if (bus.count !== 4'd0 || bus.iss_valid !== 1'b0 || bus.disp_ready !== 1'b1) begin
                bad++; $display("FAIL fl_clear mode=%0d count=%0d valid=%0b ready=%0b exp 0/0/1", mode, bus.count, bus.iss_valid, bus.disp_ready);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            bus.iss_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 6) begin
                case ($urandom_range(0, 4))
                    0: bus.disp_opcode = OP_RTYPE;
                    1: bus.disp_opcode = OP_ITYPE;
                    2: bus.disp_opcode = OP_LOAD;
                    3: bus.disp_opcode = OP_STORE;
                    default: bus.disp_opcode = 7'($urandom);
                endcase
                bus.disp_valid = 1;
                bus.disp_func3 = 3'($urandom); bus.disp_func7 = 7'($urandom);
                bus.disp_ps1 = 6'($urandom_range(0, 15)); bus.disp_ps2 = 6'($urandom_range(0, 15));
                bus.disp_pd = 6'($urandom); bus.disp_imm = $urandom;
                bus.disp_rs1_rdy = ($urandom_range(0, 2) == 0); bus.disp_rs2_rdy = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 9) < 4) begin bus.wb_valid = 1; bus.wb_pd = 6'($urandom_range(0, 15)); end
            if ($urandom_range(0, 99) < 2) bus.flush = 1;
            reset = ($urandom_range(0, 199) == 0);
            settle();
            total++; if (bus.iss_valid !== e_valid) begin bad++; $display("FAIL rnd_iss_valid cyc=%0d got=%0b exp=%0b", c, bus.iss_valid, e_valid); end
            total++; if (act_pay() !== e_pay) begin bad++; $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", c, act_pay(), e_pay); end
            total++; if (bus.count !== e_count) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, bus.count, e_count); end
            total++; if (bus.disp_ready !== e_dready) begin bad++; $display("FAIL rnd_disp_ready cyc=%0d got=%0b exp=%0b", c, bus.disp_ready, e_dready); end
            advance();
        end
        idle_inputs(); reset = 0;
    endtask

    initial begin
        idle_inputs();
        bus.iss_ready = 0;
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_age_order();
        test_imm();
        test_full();
        test_flush_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Out-of-order issue queue feeding the single integer ALU. Holds renamed ALU/load/store-address micro-ops from dispatch, tracks source-operand readiness by physical-register tag, wakes entries from the writeback broadcast, and issues the oldest ready entry to the ALU each cycle. Sits between rename/dispatch and the register-read/ALU stage.

## Interface
- `DEPTH`, default 8: number of queue entries.
- `PREG_W`, default 6: physical register tag width. Tag 0 is the hardwired zero register.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `flush`  in  1  discard all entries and any pending issue
- `disp_valid`  in  1  dispatch request
- `disp_ready`  out  1  queue can accept this cycle
- `disp_opcode`  in  7  opcode
- `disp_func3`  in  3  func3
- `disp_func7`  in  7  func7
- `disp_ps1`, `disp_ps2`  in  PREG_W  source tags
- `disp_pd`  in  PREG_W  destination tag
- `disp_imm`  in  32  sign-extended immediate
- `disp_rs1_rdy`, `disp_rs2_rdy`  in  1  source ready at rename
- `wb_valid`  in  1  writeback broadcast valid
- `wb_pd`  in  PREG_W  tag being written back
- `iss_valid`  out  1  issue slot valid
- `iss_ready`  in  1  ALU stage accepts
- `iss_opcode`, `iss_func3`, `iss_func7`, `iss_ps1`, `iss_ps2`, `iss_pd`, `iss_imm`  out  as dispatch  selected entry fields
- `count`  out  $clog2(DEPTH)+1  valid entries

## Operation
- Entry: valid, opcode, func3, func7, ps1, ps2, pd, imm, rdy1, rdy2.
- Dispatch accepted when `disp_valid && disp_ready`; written into the lowest-index invalid entry.
- Ready at write: `rdyN = disp_rsN_rdy | (psN == 0) | (wb_valid && wb_pd == psN)`. `rdy2` is forced to 1 for opcode 0010011 (ADDI/ANDI) and 0000011 (LW), which use `imm` instead of rs2.
- Wakeup: each cycle with `wb_valid`, every valid entry with `psN == wb_pd` sets `rdyN`. `wb_pd == 0` is ignored.
- Age: a DEPTH x DEPTH age matrix, where `old[i][j]=1` means i is older than j. On a write to slot k, clear row k and set column k for every other valid entry.
- Select: among entries with valid & rdy1 & rdy2, pick the one with no older ready entry. `iss_*` are combinational from the selected entry. `iss_valid` is 1 iff any entry is ready.
- Issue: on `iss_valid && iss_ready`, the selected entry is invalidated at the clock edge.
- `disp_ready = (count < DEPTH)`, based on registered count only. A same-cycle issue does not free space for a same-cycle dispatch.
- `count` is the registered population: +1 on dispatch, −1 on issue, unchanged if both occur.
- Flush: all entries invalid and `count=0` at the edge. Flush beats same-cycle dispatch and issue; neither takes effect.
- Reset: identical to flush. Also clears the age matrix. Outputs after reset: `disp_ready=1`, `iss_valid=0`, `iss_*=0`, `count=0`.
- When `iss_valid=0`, `iss_*` drive 0.

## Timing
- Dispatch with both sources ready in cycle t: entry written at the end of t; `iss_valid=1` in t+1.
- `wb_valid` for a tag in cycle t: matching entries become eligible in t+1.
- This also holds for an entry dispatched in cycle t with that tag (write-time bypass).
- Backpressure: while `iss_ready=0`, the selected entry stays. It is replaced only if a strictly older entry becomes ready.
- No combinational path from `iss_ready` or `disp_valid` to `disp_ready`.
- Reset mid-operation: all state cleared on the same edge regardless of other inputs.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_RTYPE=0110011`, `OP_ITYPE=0010011`, `OP_LOAD=0000011`, `OP_STORE=0100011`
  - `iq_entry_t` struct
  - `PREG_W` default
- Sub-module `iq_age_matrix`:
  - inputs: write enable and index, valid vector, request (ready) vector
  - output: one-hot oldest-grant vector
- Top level holds entry storage, wakeup, allocation and counters.

## Test plan
- Reset, then dispatch ADD (ps1=5, ps2=6, pd=7, both ready) → `iss_valid=1` next cycle with `iss_pd=7`; with `iss_ready=1`, `count` goes 1→0.
- Dispatch SUB (ps1=9 not ready, ps2=0) → `iss_valid=0`; `wb_pd=9` in cycle t → issues in t+1. Repeat with `wb_pd=9` in the dispatch cycle → issues next cycle.
- Dispatch A (ps1=12 not ready), then B (ready) → B issues first. Hold `iss_ready=0`, wake 12 → A becomes selected (older) and stays stable until accepted.
- ADDI with `disp_rs2_rdy=0` and ps1 ready → issues next cycle (rs2 ignored).
- Fill 8 entries with unready ops → `disp_ready=0`, `count=8`, and a 9th `disp_valid` is ignored. Wake one and issue it → `disp_ready=1` the following cycle.
- With 4 entries, assert `flush` together with `disp_valid` → `count=0` and `iss_valid=0` next cycle. Repeat with `reset` → same result.
